// File: rtl/fp_alu_pkg.sv
// ============================================================================
// Package     : fp_alu_pkg
// Description : Shared types and constants for the byte-serial FP32 ALU host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_alu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RECV  = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int OPERAND_BYTES = 4;
   localparam int RESULT_BYTES  = 4;

endpackage

`default_nettype wire

// File: rtl/fp_alu_host_ser.sv
// ============================================================================
// Module      : fp_alu_host_ser
// Description : Operand serialiser; loads {B,A} and shifts it out LSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_alu_host_ser
   import fp_alu_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_load,
   input  logic [16*OPERAND_BYTES-1:0]    i_data,
   input  logic                           i_shift,
   output logic [7:0]                     o_byte
);

   localparam int SH_W = 16 * OPERAND_BYTES;

   logic [SH_W-1:0] r_sh;
   logic [7:0]      r_byte;

   // The output byte is zero whenever no shift is requested, so the bus idles low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh   <= '0;
         r_byte <= '0;
      end else if (i_load) begin
         r_sh   <= i_data;
         r_byte <= '0;
      end else if (i_shift) begin
         r_byte <= r_sh[7:0];
         r_sh   <= {8'h00, r_sh[SH_W-1:8]};
      end else begin
         r_byte <= '0;
      end
   end

   assign o_byte = r_byte;

endmodule

`default_nettype wire

// File: rtl/fp_alu_host.sv
// ============================================================================
// Module      : fp_alu_host
// Description : Host initiator for the byte-serial FP32 add/sub ALU.
//               Optional WAIT timeout enabled by defining FP_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_alu_host
   import fp_alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [7:0]  alu_in,
   output logic        alu_start,
   output logic        alu_opcode,
   input  logic [7:0]  alu_out,
   input  logic        alu_done
);

   localparam logic [2:0] LAST_K  = 3'(2 * OPERAND_BYTES - 1);
   localparam logic [1:0] LAST_RX = 2'(RESULT_BYTES - 1);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_tmo_range_chk
      $error("fp_alu_host: TIMEOUT_CYCLES must be in 1..255");
   end

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_k;
   logic [1:0]  r_cnt;
   logic        r_op;
   logic        r_alu_start;
   logic        r_alu_opcode;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_data;
   logic        w_accept;
   logic        w_fail;
   logic        w_tmo_hit;
   logic        w_op;
   logic        w_ser_shift;
   logic        w_in_txn;

   assign w_accept    = (r_state == ST_IDLE) && req_valid;
   assign w_op        = (r_state == ST_IDLE) ? req_op : r_op;
   assign w_ser_shift = (w_next == ST_SEND);
   assign w_in_txn    = (w_next == ST_START) || (w_next == ST_SEND) ||
                        (w_next == ST_WAIT)  || (w_next == ST_RECV);

`ifdef FP_HOST_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_tmo;

   // Held at zero outside WAIT, so every WAIT visit starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
      end else if (r_state != ST_WAIT) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + 8'd1;
      end
   end

   assign w_tmo_hit = (r_tmo == TMO_LAST);
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_fail = 1'b0;
      case (r_state)
         ST_IDLE:  if (req_valid) w_next = ST_START;
         ST_START: w_next = ST_SEND;
         ST_SEND:  if (r_k == LAST_K) w_next = ST_WAIT;
         ST_WAIT: begin
            if (alu_done) begin
               w_next = ST_RECV;
            end else if (w_tmo_hit) begin
               w_next = ST_RESP;
               w_fail = 1'b1;
            end
         end
         ST_RECV: begin
            if (!alu_done) begin
               w_next = ST_RESP;
               w_fail = 1'b1;
            end else if (r_cnt == LAST_RX) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k          <= '0;
         r_cnt        <= '0;
         r_op         <= 1'b0;
         r_alu_start  <= 1'b0;
         r_alu_opcode <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_alu_start  <= (w_next == ST_START);
         r_rsp_valid  <= (w_next == ST_RESP);
         r_alu_opcode <= w_in_txn ? w_op : 1'b0;
         r_k          <= (r_state == ST_SEND) ? r_k + 3'd1 : 3'd0;
         if (w_accept) begin
            r_op       <= req_op;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
         end
         if (r_state == ST_WAIT && alu_done) begin
            r_rsp_data[7:0] <= alu_out;
            r_cnt           <= 2'd1;
         end
         if (r_state == ST_RECV && alu_done) begin
            r_rsp_data[{r_cnt, 3'b000} +: 8] <= alu_out;
            r_cnt                            <= r_cnt + 2'd1;
         end
         if (w_fail) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

   fp_alu_host_ser u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept),
      .i_data  ({req_b, req_a}),
      .i_shift (w_ser_shift),
      .o_byte  (alu_in)
   );

   assign req_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign alu_start  = r_alu_start;
   assign alu_opcode = r_alu_opcode;

endmodule

`default_nettype wire

// File: tb/tb_fp_alu_host.sv
// ============================================================================
// Module      : tb_fp_alu_host
// Description : Scoreboard bench for fp_alu_host with an emulated ALU responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_alu_host;
   import fp_alu_pkg::*;

   localparam int TMO = 32;
`ifdef FP_HOST_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [7:0]  alu_in;
   logic        alu_start;
   logic        alu_opcode;
   logic [7:0]  alu_out;
   logic        alu_done;

   fp_alu_host #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .alu_in     (alu_in),
      .alu_start  (alu_start),
      .alu_opcode (alu_opcode),
      .alu_out    (alu_out),
      .alu_done   (alu_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;
   int pending  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        op;
      int          d;
      int          nb;
      bit          extra;
   } rtx_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          c0;
      int          lat;
      int          bp;
   } etx_t;

   rtx_t rq[$];
   etx_t sq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Operand byte k on the bus: A bytes 0..3 then B bytes 0..3.
   function automatic logic [7:0] op_byte(input logic [31:0] a, input logic [31:0] b, input int k);
      logic [31:0] w;
      w = (k < 4) ? a : b;
      return w[8*(k%4) +: 8];
   endfunction

   // Bytes delivered under done survive; the rest read zero.
   function automatic logic [31:0] model_data(input logic [31:0] res, input int nb);
      logic [31:0] v;
      v = '0;
      for (int j = 0; j < 4; j++) begin
         if (j < nb) v[8*j +: 8] = res[8*j +: 8];
      end
      return v;
   endfunction

   function automatic int model_lat(input int d, input int nb);
      if (nb >= 4) return 15 + d;
      if (nb > 0)  return 12 + d + nb;
      return 10 + TMO;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] res, input int d, input int nb, input int bp,
                        input bit extra, input bit track, output int c0);
      rtx_t t;
      etx_t e;
      int   w;
      if (track) begin
         t.a = a; t.b = b; t.op = op; t.res = res; t.d = d; t.nb = nb; t.extra = extra;
         rq.push_back(t);
      end
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      req_op = 1'($urandom);
      if (track && (nb > 0 || TMO_EN)) begin
         e.data = model_data(res, nb);
         e.err  = (nb < 4);
         e.c0   = c0;
         e.lat  = model_lat(d, nb);
         e.bp   = bp;
         sq.push_back(e);
         pending++;
      end
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (pending != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 64'(pending), 64'd0);
   endtask

   // ALU responder: checks the serialised operands, then returns result bytes.
   initial begin
      rtx_t t;
      alu_done = 1'b0;
      alu_out  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n && alu_start && rq.size() != 0) begin
            t = rq.pop_front();
            chk("opcode_start", 64'(alu_opcode), 64'(t.op));
            chk("alu_in_start", 64'(alu_in), 64'd0);
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               chk("alu_in_byte", 64'(alu_in), 64'(op_byte(t.a, t.b, k)));
               chk("opcode_send", 64'(alu_opcode), 64'(t.op));
            end
            @(negedge clk);
            chk("alu_in_exec", 64'(alu_in), 64'd0);
            chk("opcode_exec", 64'(alu_opcode), 64'(t.op));
            @(posedge clk);
            #1;
            repeat (t.d) begin
               @(posedge clk);
               #1;
            end
            for (int j = 0; j < t.nb; j++) begin
               alu_done = 1'b1;
               alu_out  = t.res[8*j +: 8];
               @(posedge clk);
               #1;
            end
            if (t.extra) begin
               repeat (2) begin
                  alu_done = 1'b1;
                  alu_out  = 8'($urandom);
                  @(posedge clk);
                  #1;
               end
            end
            alu_done = 1'b0;
            alu_out  = 8'h00;
         end
      end
   end

   // Response monitor / scoreboard.
   initial begin
      etx_t e;
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid) begin
            if (sq.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
               rsp_ready = 1'b1;
               @(posedge clk);
               #1;
               rsp_ready = 1'b0;
            end else begin
               e = sq.pop_front();
               chk("rsp_latency", 64'(cyc - e.c0), 64'(e.lat));
               chk("rsp_data", 64'(rsp_data), 64'(e.data));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               for (int i = 0; i < e.bp; i++) begin
                  @(negedge clk);
                  chk("bp_valid", 64'(rsp_valid), 64'd1);
                  chk("bp_data", 64'(rsp_data), 64'(e.data));
                  chk("bp_req_ready", 64'(req_ready), 64'd0);
               end
               rsp_ready = 1'b1;
               @(posedge clk);
               #1;
               rsp_ready = 1'b0;
               @(negedge clk);
               chk("post_req_ready", 64'(req_ready), 64'd1);
               chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
               chk("post_opcode", 64'(alu_opcode), 64'd0);
               pending--;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          c0;
      int          nb;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_alu_in", 64'(alu_in), 64'd0);
      chk("rst_alu_start", 64'(alu_start), 64'd0);
      chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      rst_n = 1'b1;

      issue(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 0, 4, 0, 1'b0, 1'b1, c0);
      issue(32'h40400000, 32'h3F800000, OP_SUB, 32'h40000000, 0, 4, 0, 1'b0, 1'b1, c0);
      issue(32'h41200000, 32'h40A00000, OP_ADD, 32'h41700000, 0, 4, 5, 1'b0, 1'b1, c0);
      issue(32'hC0000000, 32'h3F000000, OP_SUB, 32'hC0200000, 10, 4, 0, 1'b0, 1'b1, c0);
      issue(32'h12345678, 32'h9ABCDEF0, OP_ADD, 32'h1122BBAA, 0, 2, 0, 1'b0, 1'b1, c0);

      for (int i = 0; i < 24; i++) begin
         nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4;
         issue($urandom, $urandom, 1'($urandom), $urandom, $urandom_range(0, 5), nb,
               $urandom_range(0, 3), (nb == 4) && ($urandom_range(0, 1) == 1), 1'b1, c0);
      end
      wait_drain();

      // ALU never answers.
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, OP_ADD, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b1, c0);
`ifdef FP_HOST_TIMEOUT_EN
      wait_drain();
`else
      while (cyc < c0 + 200) @(negedge clk);
      chk("hang_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("hang_req_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif

      // Reset in the middle of SEND abandons the transaction.
      issue(32'h11223344, 32'h55667788, OP_SUB, 32'h0, 0, 0, 0, 1'b0, 1'b0, c0);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_alu_in", 64'(alu_in), 64'h11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_start", 64'(alu_start), 64'd0);
      chk("mid_rst_alu_in", 64'(alu_in), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
      chk("mid_rst_opcode", 64'(alu_opcode), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 1, 4, 2, 1'b1, 1'b1, c0);
      wait_drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
